// File: rtl/ifu_fbq_pkg.sv
// IFU fetch buffer queue: shared types and defaults.
// Entry layout carried from F2 into the aligner.
package ifu_fbq_pkg;

  localparam int FBQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [28:0] pc;
    logic [1:0]  off;
    logic        fault;
  } fbq_entry_t;

endpackage

// File: rtl/ifu_fbq_mem.sv
// IFU fetch buffer queue storage.
// One gated write port, two combinational read ports.
module ifu_fbq_mem
  import ifu_fbq_pkg::*;
#(
  parameter int DEPTH = FBQ_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fbq_entry_t      wdata,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output fbq_entry_t      rdata0,
  output fbq_entry_t      rdata1
);

  fbq_entry_t mem_q [DEPTH];

  // Entries change only on an accepted write; no reset needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/ifu_fbq_ctl.sv
// IFU fetch buffer queue control: pointers, occupancy,
// consume acceptance, error pulse and masked entry views.
module ifu_fbq_ctl
  import ifu_fbq_pkg::*;
#(
  parameter int FBQ_DEPTH = FBQ_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_valid,
  input  logic [63:0]                  wr_data,
  input  logic [28:0]                  wr_pc,
  input  logic [1:0]                   wr_off,
  input  logic                         wr_fault,
  input  logic [1:0]                   aln_consume,
  output logic                         fb0_valid,
  output logic [63:0]                  fb0_data,
  output logic [28:0]                  fb0_pc,
  output logic [1:0]                   fb0_off,
  output logic                         fb0_fault,
  output logic                         fb1_valid,
  output logic [63:0]                  fb1_data,
  output logic [28:0]                  fb1_pc,
  output logic [1:0]                   fb1_off,
  output logic                         fb1_fault,
  output logic                         ifu_fb_consume1,
  output logic                         ifu_fb_consume2,
  output logic [$clog2(FBQ_DEPTH):0]   fbq_count,
  output logic                         fbq_full,
  output logic                         fbq_empty,
  output logic                         fbq_err
);

  localparam int AW = $clog2(FBQ_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEP = PW'(FBQ_DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] TWO = PW'(2);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          err_q, err_d;

  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_left;
  logic [PW-1:0] cons_n;
  logic          cons1;
  logic          cons2;
  logic          cons_bad;
  logic          wr_acc;
  logic          wr_drop;
  logic          mem_we;

  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1;
  fbq_entry_t    wr_ent;
  fbq_entry_t    rd0;
  fbq_entry_t    rd1;
  fbq_entry_t    v0;
  fbq_entry_t    v1;

  // Occupancy, consume acceptance and write admission.
  always_comb begin
    cnt      = wptr_q - rptr_q;
    cons1    = (aln_consume == 2'd1)
             && (cnt >= ONE);
    cons2    = (aln_consume == 2'd2)
             && (cnt >= TWO);
    cons_bad = (aln_consume != 2'd0)
             && !cons1 && !cons2;
    cons_n   = '0;
    if (cons2) begin
      cons_n = TWO;
    end else if (cons1) begin
      cons_n = ONE;
    end
    cnt_left = cnt - cons_n;
    wr_acc   = wr_valid && !flush
             && (cnt_left < DEP);
    wr_drop  = wr_valid && !flush
             && !(cnt_left < DEP);
  end

  // Pointer and error next state; flush wins over traffic.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    err_d  = 1'b0;
    if (flush) begin
      rptr_d = wptr_q;
    end else begin
      rptr_d = rptr_q + cons_n;
      if (wr_acc) begin
        wptr_d = wptr_q + ONE;
      end
      err_d = wr_drop || cons_bad;
    end
  end

  // Control state; reset overrides every same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  assign mem_we = wr_acc && !rst;
  assign ra0    = rptr_q[AW-1:0];
  assign ra1    = rptr_q[AW-1:0] + AW'(1);

  assign wr_ent.data  = wr_data;
  assign wr_ent.pc    = wr_pc;
  assign wr_ent.off   = wr_off;
  assign wr_ent.fault = wr_fault;

  ifu_fbq_mem #(
    .DEPTH (FBQ_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (wptr_q[AW-1:0]),
    .wdata  (wr_ent),
    .raddr0 (ra0),
    .raddr1 (ra1),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  // Entry views, zeroed while the slot holds nothing.
  always_comb begin
    fb0_valid = (cnt >= ONE);
    fb1_valid = (cnt >= TWO);
    v0        = fb0_valid ? rd0 : '0;
    v1        = fb1_valid ? rd1 : '0;
  end

  assign fb0_data  = v0.data;
  assign fb0_pc    = v0.pc;
  assign fb0_off   = v0.off;
  assign fb0_fault = v0.fault;
  assign fb1_data  = v1.data;
  assign fb1_pc    = v1.pc;
  assign fb1_off   = v1.off;
  assign fb1_fault = v1.fault;

  assign ifu_fb_consume1 = cons1 && !flush && !rst;
  assign ifu_fb_consume2 = cons2 && !flush && !rst;

  assign fbq_count = cnt;
  assign fbq_full  = (cnt == DEP);
  assign fbq_empty = (cnt == '0);
  assign fbq_err   = err_q;

endmodule

// File: tb/tb_ifu_fbq_ctl.sv
// Directed bench for the IFU fetch buffer queue control.
// Linear stimulus with hand-computed expectations.
module tb_ifu_fbq_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wr_valid;
  logic [63:0] wr_data;
  logic [28:0] wr_pc;
  logic [1:0]  wr_off;
  logic        wr_fault;
  logic [1:0]  aln_consume;
  logic        fb0_valid, fb1_valid;
  logic [63:0] fb0_data, fb1_data;
  logic [28:0] fb0_pc, fb1_pc;
  logic [1:0]  fb0_off, fb1_off;
  logic        fb0_fault, fb1_fault;
  logic        c1, c2;
  logic [2:0]  fbq_count;
  logic        fbq_full, fbq_empty, fbq_err;

  int total = 0;
  int bad   = 0;

  logic [28:0] q[$];
  int          ecn;
  logic        eerr;
  logic [28:0] p;

  always #5 clk = ~clk;

  ifu_fbq_ctl #(.FBQ_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_pc           (wr_pc),
    .wr_off          (wr_off),
    .wr_fault        (wr_fault),
    .aln_consume     (aln_consume),
    .fb0_valid       (fb0_valid),
    .fb0_data        (fb0_data),
    .fb0_pc          (fb0_pc),
    .fb0_off         (fb0_off),
    .fb0_fault       (fb0_fault),
    .fb1_valid       (fb1_valid),
    .fb1_data        (fb1_data),
    .fb1_pc          (fb1_pc),
    .fb1_off         (fb1_off),
    .fb1_fault       (fb1_fault),
    .ifu_fb_consume1 (c1),
    .ifu_fb_consume2 (c2),
    .fbq_count       (fbq_count),
    .fbq_full        (fbq_full),
    .fbq_empty       (fbq_empty),
    .fbq_err         (fbq_err)
  );

  function automatic logic [63:0] pd(input logic [28:0] a);
    return {a[15:0], ~a[15:0], a[15:0] ^ 16'h5a5a, 16'h1234};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_wr(input logic v, input logic [28:0] a);
    wr_valid = v;
    wr_pc    = a;
    wr_data  = pd(a);
    wr_off   = a[1:0];
    wr_fault = a[2];
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    aln_consume = 2'd0;
    drv_wr(1'b0, 29'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_count", fbq_count, 0);
    chk("rst_empty", fbq_empty, 1);
    chk("rst_full", fbq_full, 0);
    chk("rst_v0", fb0_valid, 0);
    chk("rst_v1", fb1_valid, 0);
    chk("rst_err", fbq_err, 0);
    chk("rst_c1", c1, 0);
    chk("rst_c2", c2, 0);
    chk("rst_d0", fb0_data, 0);
    chk("rst_d1", fb1_data, 0);

    drv_wr(1'b1, 29'h100);
    step();
    chk("w1_count", fbq_count, 1);
    chk("w1_pc0", fb0_pc, 29'h100);
    chk("w1_v1", fb1_valid, 0);
    drv_wr(1'b1, 29'h101);
    step();
    drv_wr(1'b1, 29'h102);
    step();
    drv_wr(1'b1, 29'h103);
    step();
    chk("w4_count", fbq_count, 4);
    chk("w4_full", fbq_full, 1);
    chk("w4_empty", fbq_empty, 0);
    chk("w4_pc0", fb0_pc, 29'h100);
    chk("w4_pc1", fb1_pc, 29'h101);
    chk("w4_d0", fb0_data, pd(29'h100));
    chk("w4_err", fbq_err, 0);

    drv_wr(1'b1, 29'h104);
    step();
    chk("drop_err", fbq_err, 1);
    chk("drop_count", fbq_count, 4);
    chk("drop_pc0", fb0_pc, 29'h100);
    drv_wr(1'b0, 29'h0);
    step();
    chk("drop_err_pulse", fbq_err, 0);
    chk("drop_count2", fbq_count, 4);

    drv_wr(1'b1, 29'h104);
    aln_consume = 2'd1;
    #1;
    chk("fullc_c1", c1, 1);
    chk("fullc_c2", c2, 0);
    step();
    chk("fullc_count", fbq_count, 4);
    chk("fullc_pc0", fb0_pc, 29'h101);
    chk("fullc_err", fbq_err, 0);

    drv_wr(1'b0, 29'h0);
    aln_consume = 2'd2;
    #1;
    chk("c2_c2", c2, 1);
    step();
    chk("c2_count", fbq_count, 2);
    chk("c2_pc0", fb0_pc, 29'h103);
    chk("c2_pc1", fb1_pc, 29'h104);
    aln_consume = 2'd1;
    step();
    chk("c1_count", fbq_count, 1);
    chk("c1_pc0", fb0_pc, 29'h104);
    chk("c1_v1", fb1_valid, 0);
    chk("c1_d1", fb1_data, 0);

    aln_consume = 2'd2;
    #1;
    chk("over_c1", c1, 0);
    chk("over_c2", c2, 0);
    step();
    chk("over_err", fbq_err, 1);
    chk("over_count", fbq_count, 1);
    aln_consume = 2'd0;

    drv_wr(1'b1, 29'h105);
    step();
    drv_wr(1'b1, 29'h106);
    step();
    drv_wr(1'b0, 29'h0);
    chk("ill_pre_count", fbq_count, 3);
    chk("ill_pre_err", fbq_err, 0);
    aln_consume = 2'd3;
    #1;
    chk("ill_c1", c1, 0);
    chk("ill_c2", c2, 0);
    step();
    chk("ill_err", fbq_err, 1);
    chk("ill_count", fbq_count, 3);
    chk("ill_pc0", fb0_pc, 29'h104);

    flush = 1'b1;
    drv_wr(1'b1, 29'h107);
    aln_consume = 2'd2;
    #1;
    chk("fl_c1", c1, 0);
    chk("fl_c2", c2, 0);
    step();
    flush = 1'b0;
    drv_wr(1'b0, 29'h0);
    aln_consume = 2'd0;
    #1;
    chk("fl_count", fbq_count, 0);
    chk("fl_empty", fbq_empty, 1);
    chk("fl_err", fbq_err, 0);
    chk("fl_v0", fb0_valid, 0);
    chk("fl_d0", fb0_data, 0);

    q.delete();
    for (int i = 0; i < 20; i++) begin
      p = 29'h200 + 29'(i);
      drv_wr(1'b1, p);
      aln_consume = (i % 2 == 0) ? 2'd1 : 2'd2;
      ecn = 0;
      if (aln_consume == 2'd1 && q.size() >= 1) ecn = 1;
      if (aln_consume == 2'd2 && q.size() >= 2) ecn = 2;
      eerr = (ecn == 0);
      #1;
      chk($sformatf("s%0d_c1", i), c1, (ecn == 1));
      chk($sformatf("s%0d_c2", i), c2, (ecn == 2));
      for (int k = 0; k < ecn; k++) void'(q.pop_front());
      if (q.size() < 4) q.push_back(p);
      step();
      chk($sformatf("s%0d_count", i), fbq_count, q.size());
      chk($sformatf("s%0d_le4", i), (fbq_count <= 3'd4), 1);
      chk($sformatf("s%0d_err", i), fbq_err, eerr);
      if (q.size() >= 1) begin
        chk($sformatf("s%0d_pc0", i), fb0_pc, q[0]);
        chk($sformatf("s%0d_d0", i), fb0_data, pd(q[0]));
        chk($sformatf("s%0d_off0", i), fb0_off, q[0][1:0]);
        chk($sformatf("s%0d_flt0", i), fb0_fault, q[0][2]);
      end
      if (q.size() >= 2) begin
        chk($sformatf("s%0d_pc1", i), fb1_pc, q[1]);
        chk($sformatf("s%0d_off1", i), fb1_off, q[1][1:0]);
        chk($sformatf("s%0d_flt1", i), fb1_fault, q[1][2]);
      end
    end
    drv_wr(1'b0, 29'h0);
    aln_consume = 2'd0;

    flush = 1'b1;
    step();
    flush = 1'b0;
    drv_wr(1'b1, 29'h300);
    step();
    drv_wr(1'b1, 29'h301);
    step();
    chk("pr_count", fbq_count, 2);
    rst = 1'b1;
    drv_wr(1'b1, 29'h302);
    aln_consume = 2'd1;
    #1;
    chk("mr_c1", c1, 0);
    step();
    rst = 1'b0;
    drv_wr(1'b0, 29'h0);
    aln_consume = 2'd0;
    #1;
    chk("mr_count", fbq_count, 0);
    chk("mr_v0", fb0_valid, 0);
    chk("mr_v1", fb1_valid, 0);
    chk("mr_empty", fbq_empty, 1);
    chk("mr_err", fbq_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fbq_ctl.md
IFU_FBQ_CTL -- requirements
Module: ifu_fbq_ctl

Interface
REQ-001 Parameter: FBQ_DEPTH, 4, number of fetch-packet entries; power of two, 2..8.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: flush  in  1  exu_flush_final | dec_takenbr; discards queue contents.
REQ-005 Port: wr_valid  in  1  F2 fetch packet valid (ifc_fetch_req_f2 & ic_hit_f2).
REQ-006 Port: wr_data  in  64  fetched instruction bytes, 4 halfwords.
REQ-007 Port: wr_pc  in  29  packet address [31:3].
REQ-008 Port: wr_off  in  2  first valid halfword in packet (fetch addr [2:1]).
REQ-009 Port: wr_fault  in  1  access fault on packet.
REQ-010 Port: aln_consume  in  2  aligner request: 0 none, 1 oldest entry, 2 two oldest, 3 illegal.
REQ-011 Port: fb0_valid/fb0_data/fb0_pc/fb0_off/fb0_fault  out  1/64/29/2/1  oldest entry view.
REQ-012 Port: fb1_valid/fb1_data/fb1_pc/fb1_off/fb1_fault  out  1/64/29/2/1  second-oldest entry view.
REQ-013 Port: ifu_fb_consume1, ifu_fb_consume2  out  1 each  accepted consume count, one-hot or zero.
REQ-014 Port: fbq_count  out  log2(FBQ_DEPTH)+1  occupied entries.
REQ-015 Port: fbq_full, fbq_empty  out  1 each  count==FBQ_DEPTH, count==0.
REQ-016 Port: fbq_err  out  1  single-cycle pulse on dropped write or illegal consume.

Function
REQ-017 Queue SHALL be circular FIFO, read/write pointers with one wrap bit each; count = wptr - rptr, modulo 2*FBQ_DEPTH.
REQ-018 Write accepted when wr_valid & ~flush & (count_after_consume < FBQ_DEPTH); entry visible on fb0/fb1 the next cycle (1-cycle latency).
REQ-019 Write when full and accepted consume==0 SHALL be dropped, state unchanged, fbq_err pulsed.
REQ-020 Write when full with accepted consume>=1 in same cycle SHALL be accepted.
REQ-021 fb0_valid = count>=1; fb1_valid = count>=2; fb views SHALL be combinational from storage at rptr and rptr+1; data outputs with valid low SHALL be zero.
REQ-022 Consume accepted: aln_consume==1 & fb0_valid -> 1; aln_consume==2 & fb1_valid -> 2; else 0.
REQ-023 aln_consume==3, or request exceeding valid entries, SHALL consume nothing and pulse fbq_err.
REQ-024 ifu_fb_consume1/2 SHALL reflect accepted count in the same cycle (combinational), forced 0 when flush.
REQ-025 flush SHALL have priority: next cycle count=0, rptr=wptr; same-cycle write and consume ignored, no fbq_err.
REQ-026 Pointer wrap from FBQ_DEPTH-1 to 0 SHALL toggle wrap bit; full/empty derived from wrap bits, never ambiguous.
REQ-027 Storage SHALL be written only on accepted write (enable-gated); unwritten entries hold value.

Reset
REQ-028 rst SHALL clear pointers, count=0, fbq_empty=1, fbq_full=0, all fb*_valid=0, consume outputs 0, fbq_err=0.
REQ-029 Storage contents need no reset; fb data outputs SHALL still read zero while invalid.
REQ-030 rst asserted mid-operation SHALL override flush, write and consume in that cycle.

Structure
REQ-031 Package ifu_fbq_pkg SHALL hold fbq_entry_t (data, pc, off, fault) and the FBQ_DEPTH default constant.
REQ-032 One sub-module ifu_fbq_mem: FBQ_DEPTH x fbq_entry_t array, 1 write port, 2 combinational read ports.
REQ-033 Pointer/count control and error logic SHALL live in ifu_fbq_ctl; target 150-300 lines total.

Verification
REQ-034 Reset then 4 writes pc 0x100..0x103, no consume -> count=4, fbq_full=1, fb0_pc=0x100, fb1_pc=0x101.
REQ-035 Full, 5th write with aln_consume=0 -> dropped, fbq_err pulse 1 cycle, count stays 4; repeat with aln_consume=1 -> accepted, count 4, fb0_pc=0x101.
REQ-036 count=1, aln_consume=2 -> no consume, consume outputs 0, fbq_err=1; aln_consume=3 at count=3 -> same.
REQ-037 count=3 with flush, wr_valid=1, aln_consume=2 same cycle -> next cycle count=0, fbq_empty=1, consume outputs 0, no fbq_err.
REQ-038 Stream 20 writes with alternating consume 1/2 across pointer wrap -> scoreboard order, off/fault fields match, count never exceeds 4.
REQ-039 rst asserted with count=2 and write pending -> next cycle count=0, all valids 0.
